// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 32-bit ALU between two requesters,
// holding operands stable and stretching mul over MUL_LATENCY exec cycles.
module alu_share_arbiter #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic        busy_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic        r_ptr, r_id, r_rsp_zero;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_rsp_data;
  logic [3:0]  r_cnt;
  logic        w_gnt, w_gnt_id, w_last;
  logic [2:0]  w_op;
  logic [31:0] w_a, w_b_raw, w_b;
  assign w_gnt    = (r_state == IDLE) && (req0_valid_i || req1_valid_i);
  assign w_gnt_id = (req0_valid_i && req1_valid_i) ? r_ptr : req1_valid_i;
  assign w_op     = w_gnt_id ? req1_op_i : req0_op_i;
  assign w_a      = w_gnt_id ? req1_a_i : req0_a_i;
  assign w_b_raw  = w_gnt_id ? req1_b_i : req0_b_i;
  // shift ops only see the 5-bit shift amount
  assign w_b      = (w_op == 3'b010 || w_op == 3'b110) ? {27'b0, w_b_raw[4:0]} : w_b_raw;
  assign w_last   = (r_state == EXEC) && (r_cnt == 4'd0);
  always_comb begin
    w_next = r_state;
    if (w_gnt) w_next = EXEC;
    else if (w_last) w_next = RESP;
    else if (r_state == RESP && rsp_ready_i) w_next = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_op       <= 3'b0;
      r_a        <= 32'b0;
      r_b        <= 32'b0;
      r_cnt      <= 4'b0;
      r_rsp_data <= 32'b0;
      r_rsp_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_id  <= w_gnt_id;
        r_op  <= w_op;
        r_a   <= w_a;
        r_b   <= w_b;
        r_ptr <= ~w_gnt_id;
        r_cnt <= (w_op == 3'b000) ? 4'(MUL_LATENCY - 1) : 4'd0;
      end else if (r_state == EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last) begin
        r_rsp_data <= alu_data_i;
        r_rsp_zero <= (alu_data_i == 32'b0);
      end
    end
  end
  assign req0_ready_o = w_gnt && !w_gnt_id;
  assign req1_ready_o = w_gnt && w_gnt_id;
  assign rsp_valid_o  = (r_state == RESP);
  assign rsp_id_o     = r_id;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_zero_o   = r_rsp_zero;
  assign busy_o       = (r_state != IDLE);
  assign alu_data1_o  = r_a;
  assign alu_data2_o  = r_b;
  assign alu_ctrl_o   = r_op;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors against alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
  logic        clk_i = 0, rst_i = 0;
  logic        req0_valid_i = 0, req1_valid_i = 0, rsp_ready_i = 0;
  logic [2:0]  req0_op_i = 0, req1_op_i = 0;
  logic [31:0] req0_a_i = 0, req0_b_i = 0, req1_a_i = 0, req1_b_i = 0;
  logic        req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_zero_o, busy_o;
  logic [31:0] rsp_data_o, alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]  alu_ctrl_o;
  int n_vec = 0, n_err = 0;

  alu_share_arbiter #(.MUL_LATENCY(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .busy_o(busy_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i)
  );

  always #5 clk_i = ~clk_i;

  // shifts use the full data2 so an unmasked shift amount shows up in the result
  always_comb begin
    alu_data_i = 32'b0;
    case (alu_ctrl_o)
      3'b000: alu_data_i = alu_data1_o * alu_data2_o;
      3'b001: alu_data_i = alu_data1_o - alu_data2_o;
      3'b010: alu_data_i = 32'($signed(alu_data1_o) >>> alu_data2_o);
      3'b011: alu_data_i = alu_data1_o & alu_data2_o;
      3'b100: alu_data_i = alu_data1_o + alu_data2_o;
      3'b101: alu_data_i = alu_data1_o ^ alu_data2_o;
      3'b110: alu_data_i = alu_data1_o << alu_data2_o;
      default: alu_data_i = alu_data1_o | alu_data2_o;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b; end
    else begin req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b; end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rv"}, rsp_valid_o, 0);
    chk({tag, "_rid"}, rsp_id_o, 0);
    chk({tag, "_rdata"}, rsp_data_o, 0);
    chk({tag, "_rzero"}, rsp_zero_o, 0);
    chk({tag, "_rdy0"}, req0_ready_o, 0);
    chk({tag, "_rdy1"}, req1_ready_o, 0);
    chk({tag, "_d1"}, alu_data1_o, 0);
    chk({tag, "_d2"}, alu_data2_o, 0);
    chk({tag, "_ctrl"}, alu_ctrl_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1;
    #1 chk_idle_outputs("reset");
    @(negedge clk_i);
    rst_i = 0;
  endtask

  // grant at cycle T, expect result at T+1+lat with ALU inputs stable throughout
  task automatic do_op(input string tag, input logic id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] b2, input logic [31:0] exp, input int lat);
    @(negedge clk_i);
    drive(id, 1, op, a, b);
    #1 chk({tag, "_ready"}, id ? req1_ready_o : req0_ready_o, 1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk_i);
      if (i == 1) drive(id, 0, 0, 0, 0);
      chk({tag, "_pend"}, rsp_valid_o, 0);
      chk({tag, "_busy"}, busy_o, 1);
      chk({tag, "_d1"}, alu_data1_o, a);
      chk({tag, "_d2"}, alu_data2_o, b2);
      chk({tag, "_ctrl"}, alu_ctrl_o, op);
    end
    @(negedge clk_i);
    chk({tag, "_valid"}, rsp_valid_o, 1);
    chk({tag, "_data"}, rsp_data_o, exp);
    chk({tag, "_zero"}, rsp_zero_o, exp == 0);
    chk({tag, "_id"}, rsp_id_o, id);
    chk({tag, "_d2r"}, alu_data2_o, b2);
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    chk({tag, "_drop"}, rsp_valid_o, 0);
    chk({tag, "_keep"}, rsp_data_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    #1 chk_idle_outputs("por");
    do_reset();

    // simultaneous requests after reset: req0 first, req1 waits, then pointer back to req0
    @(negedge clk_i);
    drive(0, 1, 3'b011, 32'h0F, 32'h3C);
    drive(1, 1, 3'b111, 32'h0F, 32'h30);
    #1 chk("arb_rdy0", req0_ready_o, 1);
    chk("arb_rdy1", req1_ready_o, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    chk("arb_wait1", req1_ready_o, 0);
    @(negedge clk_i);
    chk("arb_v0", rsp_valid_o, 1);
    chk("arb_data0", rsp_data_o, 32'h0C);
    chk("arb_id0", rsp_id_o, 0);
    rsp_ready_i = 1;
    #1 chk("arb_hs_nogrant", req1_ready_o, 0);
    @(negedge clk_i);
    rsp_ready_i = 0;
    #1 chk("arb_rdy1b", req1_ready_o, 1);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("arb_v1", rsp_valid_o, 1);
    chk("arb_data1", rsp_data_o, 32'h3F);
    chk("arb_id1", rsp_id_o, 1);
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    drive(0, 1, 3'b100, 32'd1, 32'd1);
    drive(1, 1, 3'b100, 32'd2, 32'd2);
    #1 chk("arb_rr_rdy0", req0_ready_o, 1);
    chk("arb_rr_rdy1", req1_ready_o, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("arb_rr_data", rsp_data_o, 32'd2);
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;

    do_reset();
    do_op("add", 0, 3'b100, 32'd5, 32'd7, 32'd7, 32'd12, 1);
    do_op("sub", 1, 3'b001, 32'd3, 32'd3, 32'd3, 32'd0, 1);
    do_op("mul", 0, 3'b000, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFD6, 3);
    do_op("srai", 1, 3'b010, 32'h80000000, 32'd33, 32'd1, 32'hC0000000, 1);
    do_op("sll", 0, 3'b110, 32'd1, 32'h24, 32'd4, 32'h10, 1);
    do_op("xor", 1, 3'b101, 32'hFF00FF00, 32'h0FF00FF0, 32'h0FF00FF0, 32'hF0F0F0F0, 1);

    // backpressure with a pending req0
    @(negedge clk_i);
    drive(1, 1, 3'b100, 32'd10, 32'd20);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 3'b111, 32'hA0, 32'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_data", rsp_data_o, 32'd30);
      chk("bp_id", rsp_id_o, 1);
      chk("bp_rdy0", req0_ready_o, 0);
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    #1 chk("bp_rdy0_after", req0_ready_o, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("bp_next_data", rsp_data_o, 32'hA5);
    chk("bp_next_id", rsp_id_o, 0);
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;

    // reset in the middle of a mul
    @(negedge clk_i);
    drive(1, 1, 3'b000, 32'd9, 32'd9);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1;
    #1 chk_idle_outputs("mid_rst");
    @(negedge clk_i);
    rst_i = 0;
    rsp_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("post_rst_rv", rsp_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    rsp_ready_i = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
